// File: rtl/dec_gpr_wb_queue_if.sv
// Handshake bundle between the late-writeback producers/consumers and the GPR writeback queue.
// The master side drives results, the port-2 free flag and the decode read addresses.
interface dec_gpr_wb_queue_if #(
    parameter int unsigned DEPTH_LOG2 = 2
);
    logic                  ld_wen;
    logic [4:0]            ld_waddr;
    logic [31:0]           ld_wd;
    logic                  ld_ready;
    logic                  div_wen;
    logic [4:0]            div_waddr;
    logic [31:0]           div_wd;
    logic                  div_ready;
    logic                  port_free;
    logic                  wen2;
    logic [4:0]            waddr2;
    logic [31:0]           wd2;
    logic [4:0]            raddr0;
    logic [4:0]            raddr1;
    logic                  pend0;
    logic                  pend1;
    logic [31:0]           fwd_d0;
    logic [31:0]           fwd_d1;
    logic [DEPTH_LOG2:0]   wbq_count;
    logic                  wbq_empty;

    modport master (
        output ld_wen, ld_waddr, ld_wd, div_wen, div_waddr, div_wd, port_free, raddr0, raddr1,
        input  ld_ready, div_ready, wen2, waddr2, wd2, pend0, pend1, fwd_d0, fwd_d1,
        input  wbq_count, wbq_empty
    );

    modport slave (
        input  ld_wen, ld_waddr, ld_wd, div_wen, div_waddr, div_wd, port_free, raddr0, raddr1,
        output ld_ready, div_ready, wen2, waddr2, wd2, pend0, pend1, fwd_d0, fwd_d1,
        output wbq_count, wbq_empty
    );
endinterface

// File: rtl/dec_gpr_wb_queue.sv
// In-order late-writeback queue feeding GPR write port 2 from load returns and the divider,
// with pending-write hazard lookup and youngest-entry forwarding for two decode reads.
module dec_gpr_wb_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input logic               clk,
    input logic               rst_l,
    dec_gpr_wb_queue_if.slave bus
);
    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;

    ptr_t             wr_ptr_q;
    ptr_t             rd_ptr_q;
    cnt_t             count_q;
    logic [DEPTH-1:0] valid_q;
    logic [4:0]       addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];

    cnt_t free;
    logic empty;
    logic ld_ready;
    logic div_ready;
    logic ld_enq;
    logic div_enq;
    logic pop;
    ptr_t div_slot;
    cnt_t enq_cnt;

    // Room is judged on registered occupancy only; a same-cycle pop does not add space.
    assign free      = cnt_t'(DEPTH) - count_q;
    assign empty     = (count_q == '0);
    assign ld_ready  = rst_l & (free != '0);
    assign div_ready = rst_l & ((free >= cnt_t'(2)) | ((free == cnt_t'(1)) & ~bus.ld_wen));

    // Writes to x0 complete the handshake but never occupy an entry.
    assign ld_enq   = bus.ld_wen & ld_ready & (bus.ld_waddr != '0);
    assign div_enq  = bus.div_wen & div_ready & (bus.div_waddr != '0);
    assign div_slot = wr_ptr_q + ptr_t'(ld_enq);
    assign enq_cnt  = cnt_t'(ld_enq) + cnt_t'(div_enq);
    assign pop      = rst_l & ~empty & bus.port_free;

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            if (pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + ptr_t'(1);
            end
            if (ld_enq) begin
                valid_q[wr_ptr_q] <= 1'b1;
            end
            if (div_enq) begin
                valid_q[div_slot] <= 1'b1;
            end
            wr_ptr_q <= wr_ptr_q + ptr_t'(enq_cnt);
            count_q  <= count_q + enq_cnt - cnt_t'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (ld_enq) begin
            addr_q[wr_ptr_q] <= bus.ld_waddr;
            data_q[wr_ptr_q] <= bus.ld_wd;
        end
        if (div_enq) begin
            addr_q[div_slot] <= bus.div_waddr;
            data_q[div_slot] <= bus.div_wd;
        end
    end

    // Walk oldest to youngest so the last match wins the forwarded data.
    logic        pend0_c;
    logic        pend1_c;
    logic [31:0] fwd0_c;
    logic [31:0] fwd1_c;
    ptr_t        idx;

    always_comb begin
        pend0_c = 1'b0;
        pend1_c = 1'b0;
        fwd0_c  = '0;
        fwd1_c  = '0;
        idx     = rd_ptr_q;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + ptr_t'(k);
            if (valid_q[idx] && (addr_q[idx] == bus.raddr0) && (bus.raddr0 != '0)) begin
                pend0_c = 1'b1;
                fwd0_c  = data_q[idx];
            end
            if (valid_q[idx] && (addr_q[idx] == bus.raddr1) && (bus.raddr1 != '0)) begin
                pend1_c = 1'b1;
                fwd1_c  = data_q[idx];
            end
        end
    end

    assign bus.ld_ready  = ld_ready;
    assign bus.div_ready = div_ready;
    assign bus.wen2      = pop;
    assign bus.waddr2    = (empty || !rst_l) ? 5'd0 : addr_q[rd_ptr_q];
    assign bus.wd2       = (empty || !rst_l) ? 32'd0 : data_q[rd_ptr_q];
    assign bus.pend0     = rst_l & pend0_c;
    assign bus.pend1     = rst_l & pend1_c;
    assign bus.fwd_d0    = rst_l ? fwd0_c : 32'd0;
    assign bus.fwd_d1    = rst_l ? fwd1_c : 32'd0;
    assign bus.wbq_count = count_q;
    assign bus.wbq_empty = empty;
endmodule

// File: tb/tb_dec_gpr_wb_queue.sv
// Directed bench for the GPR late-writeback queue: reset, drain order, priority, hazards, x0.
module tb_dec_gpr_wb_queue;
    logic clk;
    logic rst_l;
    int   vectors;
    int   miscompares;

    dec_gpr_wb_queue_if #(.DEPTH_LOG2(2)) bus ();

    dec_gpr_wb_queue #(.DEPTH(4), .DEPTH_LOG2(2)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.ld_wen    = 1'b0;
        bus.ld_waddr  = 5'd0;
        bus.ld_wd     = 32'd0;
        bus.div_wen   = 1'b0;
        bus.div_waddr = 5'd0;
        bus.div_wd    = 32'd0;
    endtask

    task automatic test_reset;
        idle_inputs();
        bus.port_free = 1'b1;
        bus.raddr0    = 5'd0;
        bus.raddr1    = 5'd0;
        bus.ld_wen    = 1'b1;
        bus.ld_waddr  = 5'd3;
        rst_l         = 1'b0;
        tick();
        tick();
        vectors++;
        if (bus.ld_ready !== 1'b0 || bus.div_ready !== 1'b0 || bus.wen2 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got ld_ready=%b div_ready=%b wen2=%b want 0 0 0",
                     bus.ld_ready, bus.div_ready, bus.wen2);
        end
        idle_inputs();
        rst_l = 1'b1;
        #1;
        vectors++;
        if (bus.wbq_count !== 3'd0 || bus.wbq_empty !== 1'b1 || bus.ld_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state: got count=%0d empty=%b ld_ready=%b want 0 1 1",
                     bus.wbq_count, bus.wbq_empty, bus.ld_ready);
        end
    endtask

    task automatic test_single;
        bus.port_free = 1'b1;
        bus.ld_wen    = 1'b1;
        bus.ld_waddr  = 5'd5;
        bus.ld_wd     = 32'hA5A5_0001;
        #1;
        vectors++;
        if (bus.wen2 !== 1'b0) begin
            miscompares++;
            $display("FAIL single_no_flowthrough: got wen2=%b want 0", bus.wen2);
        end
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (bus.wen2 !== 1'b1 || bus.waddr2 !== 5'd5 || bus.wd2 !== 32'hA5A5_0001) begin
            miscompares++;
            $display("FAIL single_write: got wen2=%b waddr2=%0d wd2=%h want 1 5 a5a50001",
                     bus.wen2, bus.waddr2, bus.wd2);
        end
        tick();
        vectors++;
        if (bus.wbq_empty !== 1'b1 || bus.wen2 !== 1'b0) begin
            miscompares++;
            $display("FAIL single_empty: got empty=%b wen2=%b want 1 0", bus.wbq_empty, bus.wen2);
        end
    endtask

    task automatic test_fill_drain;
        bus.port_free = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            bus.ld_wen   = 1'b1;
            bus.ld_waddr = 5'(i);
            bus.ld_wd    = 32'h100 + 32'(i);
            tick();
        end
        idle_inputs();
        bus.raddr0 = 5'd3;
        #1;
        vectors++;
        if (bus.wbq_count !== 3'd4 || bus.ld_ready !== 1'b0 || bus.div_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_full: got count=%0d ld_ready=%b div_ready=%b want 4 0 0",
                     bus.wbq_count, bus.ld_ready, bus.div_ready);
        end
        vectors++;
        if (bus.pend0 !== 1'b1 || bus.fwd_d0 !== 32'h103) begin
            miscompares++;
            $display("FAIL fill_hazard: got pend0=%b fwd_d0=%h want 1 00000103",
                     bus.pend0, bus.fwd_d0);
        end
        bus.port_free = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            vectors++;
            if (bus.wen2 !== 1'b1 || bus.waddr2 !== 5'(i) || bus.wd2 !== 32'h100 + 32'(i)) begin
                miscompares++;
                $display("FAIL drain_order[%0d]: got wen2=%b waddr2=%0d wd2=%h want 1 %0d %h",
                         i, bus.wen2, bus.waddr2, bus.wd2, i, 32'h100 + 32'(i));
            end
            tick();
        end
        vectors++;
        if (bus.wbq_empty !== 1'b1 || bus.pend0 !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_empty: got empty=%b pend0=%b want 1 0", bus.wbq_empty, bus.pend0);
        end
        bus.raddr0 = 5'd0;
    endtask

    task automatic test_div_priority;
        bus.port_free = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            bus.ld_wen   = 1'b1;
            bus.ld_waddr = 5'(i);
            bus.ld_wd    = 32'h200 + 32'(i);
            tick();
        end
        bus.ld_wen    = 1'b1;
        bus.ld_waddr  = 5'd8;
        bus.ld_wd     = 32'h300;
        bus.div_wen   = 1'b1;
        bus.div_waddr = 5'd9;
        bus.div_wd    = 32'h400;
        #1;
        vectors++;
        if (bus.wbq_count !== 3'd3 || bus.ld_ready !== 1'b1 || bus.div_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_arb: got count=%0d ld_ready=%b div_ready=%b want 3 1 0",
                     bus.wbq_count, bus.ld_ready, bus.div_ready);
        end
        tick();
        bus.ld_wen = 1'b0;
        #1;
        vectors++;
        if (bus.wbq_count !== 3'd4 || bus.div_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_full: got count=%0d div_ready=%b want 4 0",
                     bus.wbq_count, bus.div_ready);
        end
        bus.port_free = 1'b1;
        #1;
        vectors++;
        if (bus.div_ready !== 1'b0 || bus.wen2 !== 1'b1 || bus.waddr2 !== 5'd1) begin
            miscompares++;
            $display("FAIL prio_pop_no_room: got div_ready=%b wen2=%b waddr2=%0d want 0 1 1",
                     bus.div_ready, bus.wen2, bus.waddr2);
        end
        tick();
        vectors++;
        if (bus.wbq_count !== 3'd3 || bus.div_ready !== 1'b1 || bus.waddr2 !== 5'd2) begin
            miscompares++;
            $display("FAIL prio_div_ready: got count=%0d div_ready=%b waddr2=%0d want 3 1 2",
                     bus.wbq_count, bus.div_ready, bus.waddr2);
        end
        tick();
        bus.div_wen = 1'b0;
        #1;
        vectors++;
        if (bus.wbq_count !== 3'd3 || bus.waddr2 !== 5'd3 || bus.wd2 !== 32'h203) begin
            miscompares++;
            $display("FAIL prio_after_div: got count=%0d waddr2=%0d wd2=%h want 3 3 00000203",
                     bus.wbq_count, bus.waddr2, bus.wd2);
        end
        tick();
        vectors++;
        if (bus.waddr2 !== 5'd8 || bus.wd2 !== 32'h300) begin
            miscompares++;
            $display("FAIL prio_ld_order: got waddr2=%0d wd2=%h want 8 00000300",
                     bus.waddr2, bus.wd2);
        end
        tick();
        vectors++;
        if (bus.wen2 !== 1'b1 || bus.waddr2 !== 5'd9 || bus.wd2 !== 32'h400) begin
            miscompares++;
            $display("FAIL prio_div_order: got wen2=%b waddr2=%0d wd2=%h want 1 9 00000400",
                     bus.wen2, bus.waddr2, bus.wd2);
        end
        tick();
        vectors++;
        if (bus.wbq_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL prio_empty: got empty=%b want 1", bus.wbq_empty);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back;
        bus.port_free = 1'b0;
        bus.ld_wen    = 1'b1;
        bus.ld_waddr  = 5'd10;
        bus.ld_wd     = 32'h510;
        bus.div_wen   = 1'b1;
        bus.div_waddr = 5'd11;
        bus.div_wd    = 32'h611;
        #1;
        vectors++;
        if (bus.ld_ready !== 1'b1 || bus.div_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_ready: got ld_ready=%b div_ready=%b want 1 1",
                     bus.ld_ready, bus.div_ready);
        end
        tick();
        idle_inputs();
        bus.raddr0 = 5'd11;
        bus.raddr1 = 5'd10;
        #1;
        vectors++;
        if (bus.wbq_count !== 3'd2 || bus.wen2 !== 1'b0 || bus.waddr2 !== 5'd10) begin
            miscompares++;
            $display("FAIL b2b_count: got count=%0d wen2=%b waddr2=%0d want 2 0 10",
                     bus.wbq_count, bus.wen2, bus.waddr2);
        end
        vectors++;
        if (bus.pend0 !== 1'b1 || bus.fwd_d0 !== 32'h611 || bus.pend1 !== 1'b1 ||
            bus.fwd_d1 !== 32'h510) begin
            miscompares++;
            $display("FAIL b2b_hazard: got pend0=%b fwd_d0=%h pend1=%b fwd_d1=%h want 1 611 1 510",
                     bus.pend0, bus.fwd_d0, bus.pend1, bus.fwd_d1);
        end
        bus.port_free = 1'b1;
        tick();
        vectors++;
        if (bus.wen2 !== 1'b1 || bus.waddr2 !== 5'd11 || bus.wd2 !== 32'h611) begin
            miscompares++;
            $display("FAIL b2b_second: got wen2=%b waddr2=%0d wd2=%h want 1 11 00000611",
                     bus.wen2, bus.waddr2, bus.wd2);
        end
        tick();
        vectors++;
        if (bus.wbq_empty !== 1'b1 || bus.pend0 !== 1'b0 || bus.fwd_d1 !== 32'd0) begin
            miscompares++;
            $display("FAIL b2b_empty: got empty=%b pend0=%b fwd_d1=%h want 1 0 0",
                     bus.wbq_empty, bus.pend0, bus.fwd_d1);
        end
        bus.raddr0 = 5'd0;
        bus.raddr1 = 5'd0;
    endtask

    task automatic test_youngest;
        bus.port_free = 1'b0;
        bus.ld_wen    = 1'b1;
        bus.ld_waddr  = 5'd7;
        bus.ld_wd     = 32'd1;
        tick();
        bus.ld_wd = 32'd2;
        tick();
        idle_inputs();
        bus.raddr0 = 5'd7;
        #1;
        vectors++;
        if (bus.pend0 !== 1'b1 || bus.fwd_d0 !== 32'd2) begin
            miscompares++;
            $display("FAIL young_fwd: got pend0=%b fwd_d0=%h want 1 2", bus.pend0, bus.fwd_d0);
        end
        bus.port_free = 1'b1;
        #1;
        vectors++;
        if (bus.wen2 !== 1'b1 || bus.wd2 !== 32'd1 || bus.pend0 !== 1'b1) begin
            miscompares++;
            $display("FAIL young_oldest_first: got wen2=%b wd2=%h pend0=%b want 1 1 1",
                     bus.wen2, bus.wd2, bus.pend0);
        end
        tick();
        vectors++;
        if (bus.wd2 !== 32'd2 || bus.pend0 !== 1'b1 || bus.fwd_d0 !== 32'd2) begin
            miscompares++;
            $display("FAIL young_second: got wd2=%h pend0=%b fwd_d0=%h want 2 1 2",
                     bus.wd2, bus.pend0, bus.fwd_d0);
        end
        tick();
        vectors++;
        if (bus.pend0 !== 1'b0 || bus.fwd_d0 !== 32'd0 || bus.wbq_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL young_drained: got pend0=%b fwd_d0=%h empty=%b want 0 0 1",
                     bus.pend0, bus.fwd_d0, bus.wbq_empty);
        end
        bus.raddr0 = 5'd0;
    endtask

    task automatic test_x0;
        bus.port_free = 1'b1;
        bus.ld_wen    = 1'b1;
        bus.ld_waddr  = 5'd0;
        bus.ld_wd     = 32'hDEAD_BEEF;
        #1;
        vectors++;
        if (bus.ld_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL x0_ready: got ld_ready=%b want 1", bus.ld_ready);
        end
        tick();
        vectors++;
        if (bus.wbq_count !== 3'd0 || bus.wen2 !== 1'b0) begin
            miscompares++;
            $display("FAIL x0_discard: got count=%0d wen2=%b want 0 0", bus.wbq_count, bus.wen2);
        end
        bus.div_wen   = 1'b1;
        bus.div_waddr = 5'd12;
        bus.div_wd    = 32'hC0C;
        tick();
        idle_inputs();
        bus.raddr1 = 5'd0;
        #1;
        vectors++;
        if (bus.wbq_count !== 3'd1 || bus.wen2 !== 1'b1 || bus.waddr2 !== 5'd12 ||
            bus.wd2 !== 32'hC0C) begin
            miscompares++;
            $display("FAIL x0_with_div: got count=%0d wen2=%b waddr2=%0d wd2=%h want 1 1 12 c0c",
                     bus.wbq_count, bus.wen2, bus.waddr2, bus.wd2);
        end
        vectors++;
        if (bus.pend1 !== 1'b0) begin
            miscompares++;
            $display("FAIL x0_no_hazard: got pend1=%b want 0", bus.pend1);
        end
        tick();
        vectors++;
        if (bus.wbq_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL x0_empty: got empty=%b want 1", bus.wbq_empty);
        end
    endtask

    task automatic test_reset_midflight;
        bus.port_free = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            bus.ld_wen   = 1'b1;
            bus.ld_waddr = 5'(i);
            bus.ld_wd    = 32'h700 + 32'(i);
            tick();
        end
        idle_inputs();
        #1;
        vectors++;
        if (bus.wbq_count !== 3'd3) begin
            miscompares++;
            $display("FAIL rst_mid_pre: got count=%0d want 3", bus.wbq_count);
        end
        rst_l         = 1'b0;
        bus.port_free = 1'b1;
        bus.ld_wen    = 1'b1;
        bus.ld_waddr  = 5'd4;
        bus.div_wen   = 1'b1;
        bus.div_waddr = 5'd5;
        bus.raddr0    = 5'd1;
        #1;
        vectors++;
        if (bus.ld_ready !== 1'b0 || bus.div_ready !== 1'b0 || bus.wen2 !== 1'b0 ||
            bus.pend0 !== 1'b0 || bus.fwd_d0 !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_mid_gated: got ld_rdy=%b div_rdy=%b wen2=%b pend0=%b fwd=%h want 0",
                     bus.ld_ready, bus.div_ready, bus.wen2, bus.pend0, bus.fwd_d0);
        end
        tick();
        vectors++;
        if (bus.wbq_count !== 3'd0 || bus.wen2 !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_cleared: got count=%0d wen2=%b want 0 0",
                     bus.wbq_count, bus.wen2);
        end
        idle_inputs();
        rst_l = 1'b1;
        #1;
        vectors++;
        if (bus.wbq_empty !== 1'b1 || bus.ld_ready !== 1'b1 || bus.pend0 !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_after: got empty=%b ld_ready=%b pend0=%b want 1 1 0",
                     bus.wbq_empty, bus.ld_ready, bus.pend0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_l       = 1'b0;
        idle_inputs();
        bus.port_free = 1'b0;
        bus.raddr0    = 5'd0;
        bus.raddr1    = 5'd0;
        test_reset();
        test_single();
        test_fill_drain();
        test_div_priority();
        test_back_to_back();
        test_youngest();
        test_x0();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion by 100000 want completion");
        $fatal(1, "simulation time limit reached");
    end
endmodule
